// File: rtl/exe_stage_pkg.sv
// Shared constants for the execute stage: ALU commands, shift types and
// forwarding selects. The decode stage imports the same package.
package exe_stage_pkg;

  localparam logic [3:0] ALU_MOV = 4'b0001;
  localparam logic [3:0] ALU_MVN = 4'b1001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_ADC = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1000;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] FWD_REG_ALT = 2'b11;

  // Operand forwarding: both register encodings fall through to the register value.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] mem_val,
                                          input logic [31:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return reg_val;
    endcase
  endfunction

  // 32-bit rotate right; an amount of 0 returns the input unchanged.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] d;
    d = {x, x} >> amt;
    return d[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU producing the result and the next {N,Z,C,V}.
module alu
  import exe_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  cmd,
  input  logic        carry_in,
  input  logic        c_cur,
  input  logic        v_cur,
  output logic [31:0] res,
  output logic [3:0]  flags
);

  logic [32:0] sum;
  logic        c;
  logic        v;

  // Subtracts are A + ~B + 1 (or + C for SBC) so bit 32 is NOT borrow.
  always_comb begin
    sum = '0;
    res = '0;
    c   = c_cur;
    v   = v_cur;
    case (cmd)
      ALU_MOV: res = b;
      ALU_MVN: res = ~b;
      ALU_AND: res = a & b;
      ALU_ORR: res = a | b;
      ALU_EOR: res = a ^ b;
      ALU_ADD, ALU_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {32'b0, (cmd == ALU_ADC) & carry_in};
        res = sum[31:0];
        c   = sum[32];
        v   = (a[31] == b[31]) && (res[31] != a[31]);
      end
      ALU_SUB, ALU_SBC: begin
        sum = {1'b0, a} + {1'b0, ~b} + {32'b0, (cmd == ALU_SBC) ? carry_in : 1'b1};
        res = sum[31:0];
        c   = sum[32];
        v   = (a[31] != b[31]) && (res[31] != a[31]);
      end
      default: res = '0;
    endcase
    flags = {res[31], (res == '0), c, v};
  end

endmodule

// File: rtl/exe_stage_val2_gen.sv
// Operand-2 generator: memory offset, rotated immediate or shifted register.
module val2_gen
  import exe_stage_pkg::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [4:0] shift_amt;
  logic [4:0] rot_amt;

  assign shift_amt = shift_operand[11:7];
  assign rot_amt   = {shift_operand[11:8], 1'b0};

  // Priority select: memory access offset, then immediate, then register shift.
  always_comb begin
    val2 = '0;
    if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, rot_amt);
    end else begin
      case (shift_operand[6:5])
        SHIFT_LSL: val2 = val_rm << shift_amt;
        SHIFT_LSR: val2 = val_rm >> shift_amt;
        SHIFT_ASR: val2 = $unsigned($signed(val_rm) >>> shift_amt);
        default:   val2 = ror32(val_rm, shift_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, operand-2 generation, ALU, branch target,
// NZCV status register and the EXE/MEM pipeline register.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic        status_w_en_in,
  input  logic        branch_taken_in,
  input  logic        imm_in,
  input  logic [3:0]  exec_cmd_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [23:0] signed_immed_24_in,
  input  logic [3:0]  dest_in,
  input  logic [11:0] shift_operand_in,
  input  logic        carry_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd_val,
  input  logic [31:0] wb_fwd_val,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status,
  output logic [31:0] alu_res,
  output logic [31:0] st_val,
  output logic [3:0]  dest,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic        mem_w_en
);

  logic [31:0] op_a;
  logic [31:0] rm_fwd;
  logic [31:0] val2;
  logic [31:0] res;
  logic [3:0]  flags;

  assign op_a   = fwd_mux(sel_src1, val_rn_in, mem_fwd_val, wb_fwd_val);
  assign rm_fwd = fwd_mux(sel_src2, val_rm_in, mem_fwd_val, wb_fwd_val);

  val2_gen u_val2_gen (
    .val_rm        (rm_fwd),
    .shift_operand (shift_operand_in),
    .imm           (imm_in),
    .mem_en        (mem_r_en_in | mem_w_en_in),
    .val2          (val2)
  );

  alu u_alu (
    .a        (op_a),
    .b        (val2),
    .cmd      (exec_cmd_in),
    .carry_in (carry_in),
    .c_cur    (status[1]),
    .v_cur    (status[0]),
    .res      (res),
    .flags    (flags)
  );

  assign branch_taken = branch_taken_in;
  assign branch_addr  = pc_in + {{6{signed_immed_24_in[23]}}, signed_immed_24_in, 2'b00};

  // Status register: loads new flags only on an unfrozen status write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      status <= '0;
    else if (status_w_en_in && !freeze)
      status <= flags;
  end

  // EXE/MEM pipeline register: holds while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res  <= '0;
      st_val   <= '0;
      dest     <= '0;
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
    end else if (!freeze) begin
      alu_res  <= res;
      st_val   <= rm_fwd;
      dest     <= dest_in;
      wb_en    <= wb_en_in;
      mem_r_en <= mem_r_en_in;
      mem_w_en <= mem_w_en_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected register state,
// a monitor pops and compares after every rising edge.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic [31:0] pc_in = '0;
  logic        mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, wb_en_in = 1'b0;
  logic        status_w_en_in = 1'b0, branch_taken_in = 1'b0, imm_in = 1'b0;
  logic [3:0]  exec_cmd_in = '0;
  logic [31:0] val_rn_in = '0, val_rm_in = '0;
  logic [23:0] signed_immed_24_in = '0;
  logic [3:0]  dest_in = '0;
  logic [11:0] shift_operand_in = '0;
  logic        carry_in = 1'b0;
  logic [1:0]  sel_src1 = '0, sel_src2 = '0;
  logic [31:0] mem_fwd_val = '0, wb_fwd_val = '0;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest;
  logic        wb_en, mem_r_en, mem_w_en;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .status_w_en_in(status_w_en_in), .branch_taken_in(branch_taken_in), .imm_in(imm_in),
    .exec_cmd_in(exec_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .signed_immed_24_in(signed_immed_24_in), .dest_in(dest_in),
    .shift_operand_in(shift_operand_in), .carry_in(carry_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
    .alu_res(alu_res), .st_val(st_val), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        mr, mw, wb, sw, bt, imm, cin, frz;
    logic [3:0]  cmd, dst;
    logic [31:0] rn, rm, mfv, wfv;
    logic [23:0] off24;
    logic [11:0] so;
    logic [1:0]  s1, s2;
  } stim_t;

  typedef struct {
    logic [31:0] res, st;
    logic [3:0]  dst, stat;
    logic [2:0]  ctl;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the registered outputs.
  logic [31:0] m_res = '0, m_st = '0;
  logic [3:0]  m_dst = '0, m_stat = '0;
  logic [2:0]  m_ctl = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_ror(input logic [31:0] x, input int unsigned n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] m, input logic [31:0] w);
    if (s == 2'd1) return m;
    if (s == 2'd2) return w;
    return r;
  endfunction

  function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                         input logic [11:0] so, input logic [31:0] rm);
    int unsigned n;
    int sx;
    if (mem) return {20'b0, so};
    if (imm) return m_ror({24'b0, so[7:0]}, 2 * so[11:8]);
    n = so[11:7];
    case (so[6:5])
      2'd0: return rm << n;
      2'd1: return rm >> n;
      2'd2: begin sx = rm; return sx >>> n; end
      default: return m_ror(rm, n);
    endcase
  endfunction

  function automatic logic [31:0] m_branch(input logic [31:0] pc, input logic [23:0] off);
    logic signed [23:0] so;
    int o;
    so = off;
    o = so;
    return pc + 32'(o * 4);
  endfunction

  // ALU reference using wide integer arithmetic for carry and overflow.
  function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                input logic [31:0] b, input logic cin,
                                input logic [3:0] cur, output logic [3:0] f,
                                output logic [31:0] r);
    longint unsigned ua, ub, us;
    longint sa, sb, ss;
    longint unsigned bor;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = cur[1]; v = cur[0]; r = '0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        us = ua + ub + ((cmd == 4'd3) ? longint'(cin) : 0);
        ss = sa + sb + ((cmd == 4'd3) ? longint'(cin) : 0);
        r = us[31:0];
        c = (us >= 64'h1_0000_0000);
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        bor = (cmd == 4'd5) ? longint'(!cin) : 0;
        ss = sa - sb - longint'(bor);
        r = 32'(ua - ub - bor);
        c = (ua >= ub + bor);
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: r = '0;
    endcase
    f = {r[31], r == 32'd0, c, v};
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s.pc = '0; s.mr = 0; s.mw = 0; s.wb = 0; s.sw = 0; s.bt = 0; s.imm = 0;
    s.cin = 0; s.frz = 0; s.cmd = '0; s.dst = '0; s.rn = '0; s.rm = '0;
    s.mfv = '0; s.wfv = '0; s.off24 = '0; s.so = '0; s.s1 = '0; s.s2 = '0;
    return s;
  endfunction

  task automatic issue(input stim_t s);
    logic [31:0] a, st, b, r;
    logic [3:0]  f;
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    freeze = s.frz; pc_in = s.pc; mem_r_en_in = s.mr; mem_w_en_in = s.mw;
    wb_en_in = s.wb; status_w_en_in = s.sw; branch_taken_in = s.bt; imm_in = s.imm;
    exec_cmd_in = s.cmd; val_rn_in = s.rn; val_rm_in = s.rm;
    signed_immed_24_in = s.off24; dest_in = s.dst; shift_operand_in = s.so;
    carry_in = s.cin; sel_src1 = s.s1; sel_src2 = s.s2;
    mem_fwd_val = s.mfv; wb_fwd_val = s.wfv;
    #1;
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, s.bt});
    chk("branch_addr", branch_addr, m_branch(s.pc, s.off24));
    a  = m_fwd(s.s1, s.rn, s.mfv, s.wfv);
    st = m_fwd(s.s2, s.rm, s.mfv, s.wfv);
    b  = m_val2(s.mr | s.mw, s.imm, s.so, st);
    m_alu(s.cmd, a, b, s.cin, m_stat, f, r);
    if (!s.frz) begin
      m_res = r; m_st = st; m_dst = s.dst; m_ctl = {s.wb, s.mr, s.mw};
      if (s.sw) m_stat = f;
    end
    e.res = m_res; e.st = m_st; e.dst = m_dst; e.stat = m_stat; e.ctl = m_ctl;
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu_res"}, alu_res, 32'd0);
    chk({tag, "_st_val"}, st_val, 32'd0);
    chk({tag, "_dest"}, {28'b0, dest}, 32'd0);
    chk({tag, "_ctl"}, {29'b0, wb_en, mem_r_en, mem_w_en}, 32'd0);
    chk({tag, "_status"}, {28'b0, status}, 32'd0);
  endtask

  // Asserts reset just after a falling edge, with freeze optionally high.
  task automatic do_reset(input logic frz);
    exp_t e;
    @(negedge clk);
    freeze = frz;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    m_res = '0; m_st = '0; m_dst = '0; m_stat = '0; m_ctl = '0;
    e.res = '0; e.st = '0; e.dst = '0; e.stat = '0; e.ctl = '0;
    q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per rising edge that the stimulus covered.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("alu_res", alu_res, e.res);
        chk("st_val", st_val, e.st);
        chk("dest", {28'b0, dest}, {28'b0, e.dst});
        chk("ctl", {29'b0, wb_en, mem_r_en, mem_w_en}, {29'b0, e.ctl});
        chk("status", {28'b0, status}, {28'b0, e.stat});
      end
    end
  end

  initial begin
    stim_t s;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);

    s = blank(); s.cmd = 4'd2; s.imm = 1; s.so = 12'h2FF; s.rn = 32'd1; s.sw = 1; s.wb = 1;
    issue(s); after_edge();
    chk("plan_add_imm", alu_res, 32'hF0000010);
    chk("plan_add_imm_n", {28'b0, status}, 32'h8);

    s = blank(); s.cmd = 4'd4; s.rn = 32'd5; s.rm = 32'd5; s.sw = 1;
    issue(s); after_edge();
    chk("plan_sub_eq", {28'b0, status}, 32'h6);
    s = blank(); s.cmd = 4'd4; s.rn = 32'd1; s.rm = 32'd5; s.sw = 1; s.frz = 1;
    issue(s); after_edge();
    chk("plan_cmp_frozen", {28'b0, status}, 32'h6);
    chk("plan_frozen_res", alu_res, 32'd0);

    s = blank(); s.cmd = 4'd2; s.rn = 32'h7FFFFFFF; s.rm = 32'd1; s.sw = 1;
    issue(s); after_edge();
    chk("plan_add_ovf", {28'b0, status}, 32'h9);
    s = blank(); s.cmd = 4'd3; s.rn = 32'hFFFFFFFF; s.cin = 1; s.sw = 1;
    issue(s); after_edge();
    chk("plan_adc_wrap", {28'b0, status}, 32'h6);

    s = blank(); s.cmd = 4'd1; s.rm = 32'h80000000; s.so = 12'h240;
    issue(s); after_edge();
    chk("plan_asr4", alu_res, 32'hF8000000);
    s = blank(); s.cmd = 4'd1; s.rm = 32'h1; s.so = 12'h0E0;
    issue(s); after_edge();
    chk("plan_ror1", alu_res, 32'h80000000);

    s = blank(); s.cmd = 4'd2; s.imm = 1; s.so = 12'h001; s.s1 = 2'b01;
    s.mfv = 32'd10; s.rn = 32'd99;
    issue(s); after_edge();
    chk("plan_fwd_add", alu_res, 32'd11);
    s.cmd = 4'd1;
    issue(s); after_edge();
    chk("plan_fwd_mov", alu_res, 32'd1);
    s = blank(); s.cmd = 4'd2; s.mw = 1; s.s2 = 2'b10; s.wfv = 32'hCAFE0123; s.rm = 32'h5;
    issue(s); after_edge();
    chk("plan_str_fwd", st_val, 32'hCAFE0123);

    s = blank(); s.bt = 1; s.pc = 32'h100; s.off24 = 24'hFFFFFE;
    issue(s);
    chk("plan_branch", branch_addr, 32'h000000F8);
    after_edge();

    s = blank(); s.cmd = 4'd2; s.rn = 32'h12345678; s.rm = 32'h1; s.sw = 1; s.wb = 1; s.dst = 4'd7;
    issue(s);
    s.frz = 1;
    issue(s);
    do_reset(1'b1);

    for (int i = 0; i < 400; i++) begin
      s.pc = $urandom; s.off24 = 24'($urandom);
      s.mr = ($urandom_range(0, 5) == 0); s.mw = ($urandom_range(0, 5) == 0);
      s.wb = 1'($urandom); s.sw = 1'($urandom); s.bt = 1'($urandom);
      s.imm = 1'($urandom); s.cin = 1'($urandom); s.frz = ($urandom_range(0, 7) == 0);
      s.cmd = 4'($urandom); s.dst = 4'($urandom);
      s.rn = $urandom; s.rm = $urandom; s.mfv = $urandom; s.wfv = $urandom;
      s.so = 12'($urandom); s.s1 = 2'($urandom); s.s2 = 2'($urandom);
      if ($urandom_range(0, 3) == 0) s.rm = {s.rm[31], 31'($urandom_range(0, 3))};
      if ($urandom_range(0, 5) == 0) s = blank();
      issue(s);
      if (i == 200) do_reset(1'b1);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline, consuming the ID/EXE pipeline register and producing the EXE/MEM pipeline register. It contains the operand-2 generator, the ALU, the branch-target adder, operand forwarding muxes and the architectural status register (NZCV). The branch outcome is combinational and feeds the IF stage and the flush of the upstream registers. All other results are registered.

## Interface
- No parameters; widths fixed (32-bit datapath, 4-bit register index).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- freeze  in  1  hold the EXE/MEM register and the status register (memory stall).
- pc_in  in  32  PC+4 of the instruction.
- mem_r_en_in, mem_w_en_in, wb_en_in, status_w_en_in, branch_taken_in, imm_in  in  1 each  control bits from ID/EXE.
- exec_cmd_in  in  4  ALU command.
- val_rn_in, val_rm_in  in  32  register operands.
- signed_immed_24_in  in  24  branch offset.
- dest_in  in  4  destination register.
- shift_operand_in  in  12  shifter operand field.
- carry_in  in  1  C flag captured with the instruction.
- sel_src1, sel_src2  in  2  forwarding select: 00 register, 01 mem_fwd_val, 10 wb_fwd_val, 11 register.
- mem_fwd_val, wb_fwd_val  in  32  forwarded results.
- branch_taken  out  1  = branch_taken_in (combinational).
- branch_addr  out  32  branch target (combinational).
- status  out  4  {N,Z,C,V} register.
- alu_res, st_val  out  32  registered ALU result and store data.
- dest  out  4  registered destination.
- wb_en, mem_r_en, mem_w_en  out  1  registered control bits.

## Operation
- Operand A = forwarding mux of val_rn_in by sel_src1. Store data = forwarding mux of val_rm_in by sel_src2. The shifter source for the register case is also the sel_src2-muxed val_rm.
- Val2 is selected in priority order:
  - mem_r_en_in|mem_w_en_in: zero-extended shift_operand[11:0].
  - imm_in: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Otherwise: muxed Rm shifted by so[11:7] with type so[6:5]. 00 LSL, 01 LSR, 10 ASR, 11 ROR. An amount of 0 means no shift.
- ALU commands:
  - 0001 MOV: B.
  - 1001 MVN: ~B.
  - 0010 ADD: A+B.
  - 0011 ADC: A+B+carry_in.
  - 0100 SUB/CMP: A-B.
  - 0101 SBC: A-B-~carry_in.
  - 0110 AND/TST: A&B.
  - 0111 ORR: A|B.
  - 1000 EOR: A^B.
  - Any other command: result 0, flags N/Z only.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = 33rd bit of the sum. For subtract, C = NOT borrow, so C=1 when A≥B unsigned.
  - V = signed overflow: operands of equal sign (after B negation for subtract) and result of differing sign.
  - Logical ops and MOV/MVN leave C and V at their current register values.
- Status register loads {N,Z,C,V} when status_w_en_in & ~freeze.
- EXE/MEM register loads alu_res, st_val, dest, wb_en, mem_r_en, mem_w_en when ~freeze; otherwise it holds.
- branch_addr = pc_in + sign_extend(signed_immed_24_in) << 2, computed with 32-bit wrap-around.

## Timing
- Reset: every registered output and status = 0, asynchronously.
- Latency: ALU result is visible on alu_res one rising edge after the instruction is presented.
- branch_taken and branch_addr are valid in the same cycle the instruction is presented (zero latency).
- freeze=1: all registers hold, including when status_w_en_in=1.
- The upstream register delivers a flushed bubble as all-zero controls. This produces wb_en=mem_r_en=mem_w_en=0 and no status write.
- Reset asserted mid-stall overrides freeze.
- Overflow and carry out of bit 31 are never truncated silently; they are captured only through C/V.

## Structure
- A shared package holds the ALU command constants, shift-type constants and forwarding-select constants. The decode stage uses the same package.
- Sub-modules:
  - val2_gen: combinational shifter/rotator.
  - alu: combinational.
- The status register and the EXE/MEM register are inline in exe_stage.

## Test plan
- ADD with imm, so=12'h2FF: Val2=32'hF000000F. With A=1, alu_res=32'hF0000010 next edge; N=1 if status_w_en.
- SUB A=5, B=5, status_w_en=1 → status=4'b0110 (Z=1, C=1); CMP issued with freeze=1 → status unchanged.
- ADD 32'h7FFFFFFF+1 → status V=1, N=1. ADC 32'hFFFFFFFF+0 with carry_in=1 → res 0, status Z=1, C=1.
- Register operand Rm=32'h80000000, so[11:7]=4, ASR → Val2=32'hF8000000; ROR by 1 of 32'h1 → 32'h80000000.
- sel_src1=01, mem_fwd_val=10, val_rn=99, MOV vs ADD with B=1 → ADD gives alu_res=11. STR with sel_src2=10 → st_val=wb_fwd_val.
- Branch with pc_in=32'h100 and imm24=24'hFFFFFE → branch_addr=32'hF8, branch_taken=1 same cycle. Async rst mid-operation → all outputs 0 immediately.
